// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: picks the next PC, holds the request address stable while
// instruction memory back-pressures, buffers redirects and drives flush/kill strobes.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    input  logic             imem_ready,
    output logic             fetch_req,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_kill,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [0:0] RUN        = 1'b0;
    localparam logic [0:0] REDIR_WAIT = 1'b1;

    logic [0:0]       stateReg, stateNext;
    logic [31:0]      pcReg, pcNext;
    logic [31:0]      pendPcReg, pendPcNext;
    logic             misalignReg, misalignNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic             acc;
    logic             redirect;
    logic [31:0]      redirTarget;
    logic             killComb;
    logic             flushAll;
    logic             flushIfidOnly;

    // The request is live in every cycle outside reset, including the first one after it.
    assign fetch_req = ~reset;
    assign acc       = fetch_req & imem_ready;
    assign pc        = pcReg;
    assign pc_plus4  = pcReg + 32'd4;

    always_comb begin
        stateNext     = stateReg;
        pcNext        = pcReg;
        pendPcNext    = pendPcReg;
        misalignNext  = misalignReg;
        cntNext       = cntReg;
        killComb      = 1'b0;
        flushAll      = 1'b0;
        flushIfidOnly = 1'b0;
        redirect      = 1'b0;
        redirTarget   = br_target;

        if (!reset) begin
            // A branch wins in either state; a jump seen while waiting is on the wrong path.
            if (br_taken) begin
                flushAll    = 1'b1;
                redirect    = 1'b1;
                redirTarget = br_target;
            end else if (stateReg == RUN && jmp_valid && !stall) begin
                flushIfidOnly = 1'b1;
                redirect      = 1'b1;
                redirTarget   = jmp_target;
            end

            if (redirect) begin
                if (redirTarget[1:0] != 2'b00) begin
                    misalignNext = 1'b1;
                end
                if (cntReg != {CNT_W{1'b1}}) begin
                    cntNext = cntReg + CNT_W'(1);
                end
                if (acc) begin
                    pcNext    = {redirTarget[31:2], 2'b00};
                    killComb  = 1'b1;
                    stateNext = RUN;
                end else begin
                    pendPcNext = {redirTarget[31:2], 2'b00};
                    stateNext  = REDIR_WAIT;
                end
            end else if (stateReg == REDIR_WAIT) begin
                if (acc) begin
                    pcNext    = pendPcReg;
                    killComb  = 1'b1;
                    stateNext = RUN;
                end
            end else if (acc) begin
                // A stalled accept refetches the same address and discards the returned word.
                if (stall) begin
                    killComb = 1'b1;
                end else begin
                    pcNext = pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= RUN;
            pcReg       <= RESET_PC;
            pendPcReg   <= 32'h0000_0000;
            misalignReg <= 1'b0;
            cntReg      <= '0;
        end else begin
            stateReg    <= stateNext;
            pcReg       <= pcNext;
            pendPcReg   <= pendPcNext;
            misalignReg <= misalignNext;
            cntReg      <= cntNext;
        end
    end

    assign fetch_kill   = killComb;
    assign flush_ifid   = flushAll | flushIfidOnly;
    assign flush_idex   = flushAll;
    assign flush_exmem  = flushAll;
    assign misalign_err = misalignReg;
    assign redirect_cnt = cntReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// stimulus checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          CW     = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          br_taken = 1'b0;
    logic [31:0]   br_target = '0;
    logic          jmp_valid = 1'b0;
    logic [31:0]   jmp_target = '0;
    logic          imem_ready = 1'b0;
    logic          fetch_req;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic          fetch_kill;
    logic          flush_ifid;
    logic          flush_idex;
    logic          flush_exmem;
    logic          misalign_err;
    logic [CW-1:0] redirect_cnt;

    int checks = 0;
    int passes = 0;

    // Model state: the PC, whether a redirect is parked, and where it points.
    logic [31:0]   mPc = '0;
    logic          mPending = 1'b0;
    logic [31:0]   mPend = '0;
    logic          mErr = 1'b0;
    logic [CW-1:0] mCnt = '0;
    logic [31:0]   nPc, nPend;
    logic          nPending, nErr;
    logic [CW-1:0] nCnt;
    logic          eReq, eKill, eFlushAll, eFlushIfid;

    pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .imem_ready(imem_ready), .fetch_req(fetch_req), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_kill(fetch_kill), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task model_eval();
        logic        acc, honoured;
        logic [31:0] tgt;
        eReq = !reset;
        acc = eReq && imem_ready;
        eKill = 1'b0; eFlushAll = 1'b0; eFlushIfid = 1'b0;
        nPc = mPc; nPending = mPending; nPend = mPend; nErr = mErr; nCnt = mCnt;
        honoured = 1'b0; tgt = '0;
        if (reset) begin
            nPc = RST_PC; nPending = 1'b0; nPend = '0; nErr = 1'b0; nCnt = '0;
        end else begin
            if (br_taken) begin
                eFlushAll = 1'b1; honoured = 1'b1; tgt = br_target;
            end else if (!mPending && jmp_valid && !stall) begin
                eFlushIfid = 1'b1; honoured = 1'b1; tgt = jmp_target;
            end
            if (honoured) begin
                if (tgt % 4 != 0) nErr = 1'b1;
                if (mCnt < 16'hFFFF) nCnt = mCnt + 1;
                if (acc) begin nPc = tgt - (tgt % 4); eKill = 1'b1; nPending = 1'b0; end
                else begin nPend = tgt - (tgt % 4); nPending = 1'b1; end
            end else if (mPending) begin
                if (acc) begin nPc = mPend; eKill = 1'b1; nPending = 1'b0; end
            end else if (acc) begin
                if (stall) eKill = 1'b1;
                else nPc = mPc + 4;
            end
        end
    endtask

    task tick();
        model_eval();
        @(posedge clk);
        mPc = nPc; mPending = nPending; mPend = nPend; mErr = nErr; mCnt = nCnt;
        #1;
    endtask

    task set_in(input logic br, input logic [31:0] bt, input logic jv,
                input logic [31:0] jt, input logic st, input logic rdy);
        br_taken = br; br_target = bt; jmp_valid = jv; jmp_target = jt;
        stall = st; imem_ready = rdy;
        #1;
    endtask

    task test_reset();
        reset = 1'b1;
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (fetch_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", fetch_req); else passes++;
        checks++; if (pc !== RST_PC) $display("FAIL rst_pc got=%h exp=%h", pc, RST_PC); else passes++;
        checks++; if ({fetch_kill, flush_ifid, flush_idex, flush_exmem, misalign_err} !== 5'b0)
            $display("FAIL rst_strobes got=%b exp=00000", {fetch_kill, flush_ifid, flush_idex, flush_exmem, misalign_err});
        else passes++;
        reset = 1'b0;
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checks++; if ({fetch_req, pc} !== {1'b1, 32'h100}) $display("FAIL seq0 got=%b/%h exp=1/100", fetch_req, pc); else passes++;
        $display("reset released: pc=%h fetch_req=%b", pc, fetch_req);
        tick();
        checks++; if (pc !== 32'h104) $display("FAIL seq1 pc got=%h exp=104", pc); else passes++;
        tick();
        checks++; if ({pc, fetch_kill, redirect_cnt} !== {32'h108, 1'b0, 16'h0})
            $display("FAIL seq2 got=%h/%b/%h exp=108/0/0000", pc, fetch_kill, redirect_cnt);
        else passes++;
        $display("sequential fetch: pc=%h cnt=%0d", pc, redirect_cnt);
    endtask

    task test_branch_accept();
        set_in(1'b1, 32'h40, 1'b0, 0, 1'b0, 1'b1);
        checks++; if ({flush_ifid, flush_idex, flush_exmem, fetch_kill} !== 4'b1111)
            $display("FAIL br_strobes got=%b exp=1111", {flush_ifid, flush_idex, flush_exmem, fetch_kill});
        else passes++;
        tick();
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checks++; if ({pc, redirect_cnt, flush_idex} !== {32'h40, 16'h1, 1'b0})
            $display("FAIL br_next got=%h/%h/%b exp=40/0001/0", pc, redirect_cnt, flush_idex);
        else passes++;
        $display("branch accepted: pc=%h cnt=%0d", pc, redirect_cnt);
    endtask

    task test_jump_wait();
        set_in(1'b1, 32'h20, 1'b0, 0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 0, 1'b1, 32'h80, 1'b0, 1'b0);
        checks++; if ({flush_ifid, flush_idex, flush_exmem, fetch_kill} !== 4'b1000)
            $display("FAIL jmp_wait_strobes got=%b exp=1000", {flush_ifid, flush_idex, flush_exmem, fetch_kill});
        else passes++;
        tick();
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++; if ({fetch_req, pc} !== {1'b1, 32'h20}) $display("FAIL jmp_hold1 got=%b/%h exp=1/20", fetch_req, pc); else passes++;
        tick();
        checks++; if (pc !== 32'h20) $display("FAIL jmp_hold2 pc got=%h exp=20", pc); else passes++;
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checks++; if (fetch_kill !== 1'b1) $display("FAIL jmp_release_kill got=%b exp=1", fetch_kill); else passes++;
        tick();
        checks++; if ({pc, redirect_cnt} !== {32'h80, 16'h3}) $display("FAIL jmp_release got=%h/%h exp=80/0003", pc, redirect_cnt); else passes++;
        $display("buffered jump taken: pc=%h cnt=%0d", pc, redirect_cnt);
    endtask

    task test_redir_override();
        set_in(1'b0, 0, 1'b1, 32'h80, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h200, 1'b0, 0, 1'b0, 1'b0);
        checks++; if ({flush_ifid, flush_idex, flush_exmem, fetch_kill} !== 4'b1110)
            $display("FAIL ovr_strobes got=%b exp=1110", {flush_ifid, flush_idex, flush_exmem, fetch_kill});
        else passes++;
        tick();
        set_in(1'b0, 0, 1'b1, 32'h300, 1'b0, 1'b0);
        checks++; if (flush_ifid !== 1'b0) $display("FAIL ovr_wrongpath_jmp got=%b exp=0", flush_ifid); else passes++;
        tick();
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        checks++; if ({pc, redirect_cnt} !== {32'h200, 16'h5}) $display("FAIL ovr_pc got=%h/%h exp=200/0005", pc, redirect_cnt); else passes++;
        $display("override in wait: pc=%h cnt=%0d", pc, redirect_cnt);
    endtask

    task test_stall_jump();
        set_in(1'b1, 32'h30, 1'b0, 0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 0, 1'b1, 32'h90, 1'b1, 1'b1);
        checks++; if ({fetch_kill, flush_ifid, flush_idex, flush_exmem} !== 4'b1000)
            $display("FAIL stall_strobes got=%b exp=1000", {fetch_kill, flush_ifid, flush_idex, flush_exmem});
        else passes++;
        tick();
        set_in(1'b0, 0, 1'b1, 32'h90, 1'b0, 1'b1);
        checks++; if ({pc, flush_ifid, fetch_kill} !== {32'h30, 1'b1, 1'b1})
            $display("FAIL stall_release got=%h/%b/%b exp=30/1/1", pc, flush_ifid, fetch_kill);
        else passes++;
        tick();
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checks++; if ({pc, redirect_cnt} !== {32'h90, 16'h7}) $display("FAIL stall_jmp got=%h/%h exp=90/0007", pc, redirect_cnt); else passes++;
        $display("stalled jump honoured later: pc=%h cnt=%0d", pc, redirect_cnt);
    endtask

    task test_wrap();
        set_in(1'b1, 32'hFFFF_FFFC, 1'b0, 0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checks++; if ({pc, pc_plus4} !== {32'hFFFF_FFFC, 32'h0}) $display("FAIL wrap_plus4 got=%h/%h exp=fffffffc/0", pc, pc_plus4); else passes++;
        tick();
        checks++; if ({pc, misalign_err} !== {32'h0, 1'b0}) $display("FAIL wrap_pc got=%h/%b exp=0/0", pc, misalign_err); else passes++;
        $display("wrap: pc=%h", pc);
    endtask

    task test_misalign();
        set_in(1'b1, 32'h43, 1'b0, 0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checks++; if ({pc, misalign_err} !== {32'h40, 1'b1}) $display("FAIL mis_set got=%h/%b exp=40/1", pc, misalign_err); else passes++;
        tick(); tick(); tick();
        checks++; if (misalign_err !== 1'b1) $display("FAIL mis_sticky got=%b exp=1", misalign_err); else passes++;
        $display("misaligned target: pc=%h err=%b", pc, misalign_err);
    endtask

    task test_reset_mid_redir();
        set_in(1'b0, 0, 1'b1, 32'h500, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        checks++; if ({pc, misalign_err, redirect_cnt} !== {RST_PC, 1'b0, 16'h0})
            $display("FAIL midrst got=%h/%b/%h exp=%h/0/0000", pc, misalign_err, redirect_cnt, RST_PC);
        else passes++;
        reset = 1'b0;
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        checks++; if (pc !== 32'h104) $display("FAIL midrst_drop pc got=%h exp=104", pc); else passes++;
        $display("reset dropped pending redirect: pc=%h", pc);
    endtask

    task test_random();
        for (int i = 0; i < 1000; i++) begin
            reset = ($urandom_range(99) == 0);
            set_in($urandom_range(7) == 0,
                   ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                   $urandom_range(5) == 0, $urandom & 32'h0000_FFFC,
                   $urandom_range(3) == 0, $urandom_range(2) != 0);
            model_eval();
            checks++;
            if ({fetch_req, pc, pc_plus4, fetch_kill, flush_ifid, flush_idex, flush_exmem, misalign_err, redirect_cnt}
                !== {eReq, mPc, mPc + 32'd4, eKill, eFlushAll | eFlushIfid, eFlushAll, eFlushAll, mErr, mCnt})
                $display("FAIL rand[%0d] got req=%b pc=%h kill=%b fl=%b%b%b err=%b cnt=%h exp req=%b pc=%h kill=%b fl=%b%b%b err=%b cnt=%h",
                         i, fetch_req, pc, fetch_kill, flush_ifid, flush_idex, flush_exmem, misalign_err, redirect_cnt,
                         eReq, mPc, eKill, eFlushAll | eFlushIfid, eFlushAll, eFlushAll, mErr, mCnt);
            else passes++;
            $display("rand %0d: rst=%b br=%b jv=%b st=%b rdy=%b pc=%h kill=%b cnt=%0d",
                     i, reset, br_taken, jmp_valid, stall, imem_ready, pc, fetch_kill, redirect_cnt);
            tick();
        end
        reset = 1'b0;
    endtask

    task test_saturation();
        reset = 1'b1;
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        set_in(1'b1, 32'h40, 1'b0, 0, 1'b0, 1'b1);
        repeat (65534) tick();
        checks++; if (redirect_cnt !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", redirect_cnt); else passes++;
        tick();
        checks++; if (redirect_cnt !== 16'hFFFF) $display("FAIL sat_hit got=%h exp=ffff", redirect_cnt); else passes++;
        repeat (4465) tick();
        checks++; if (redirect_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", redirect_cnt); else passes++;
        $display("70000 redirects: cnt=%h", redirect_cnt);
        set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_branch_accept();
        test_jump_wait();
        test_redir_override();
        test_stall_jump();
        test_wrap();
        test_misalign();
        test_reset_mid_redir();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
